// File: rtl/sevenseg_mux_decoder_if.sv
// Display-path bundle between a two-digit multiplexed 7-segment driver and its decoder.
//   en1_n, en2_n : digit-0 / digit-1 selects, active-low
//   seg          : segment lines {a,b,c,d,e,f,g}, active-high, a = MSB
//   dp           : decimal point, active-high
//   data         : last reassembled byte {hi,lo}
//   data_valid   : one-cycle pulse when data updates
//   data_changed : one-cycle pulse with data_valid when the byte differs from the previous one
//   dp_out       : dp captured with the latest accepted digit
//   code_err     : one-cycle pulse when an accepted pattern is not a hex glyph
// master = the side driving the display pins, slave = the decoder.
interface sevenseg_mux_decoder_if;
    logic       en1_n;
    logic       en2_n;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] data;
    logic       data_valid;
    logic       data_changed;
    logic       dp_out;
    logic       code_err;

    modport master (
        output en1_n, en2_n, seg, dp,
        input  data, data_valid, data_changed, dp_out, code_err
    );

    modport slave (
        input  en1_n, en2_n, seg, dp,
        output data, data_valid, data_changed, dp_out, code_err
    );
endinterface

// File: rtl/sevenseg_mux_decoder.sv
// Receive-side decoder for a two-digit multiplexed 7-segment display.
// Synchronizes the display pins, waits for each mux phase to settle, decodes the
// segment glyph back to a hex nibble and reassembles the displayed byte.
//   CLK : system clock
//   rst : synchronous active-high reset
//   bus : sevenseg_mux_decoder_if.slave (display pins in, decoded byte and pulses out)
module sevenseg_mux_decoder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    sevenseg_mux_decoder_if.slave bus
);

    localparam int unsigned VEC_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_LO   = 2'd1;
    localparam logic [1:0] SEL_HI   = 2'd2;

    // Sampled vector layout: {en1_n, en2_n, seg[6:0], dp}
    logic [VEC_W-1:0] raw_vec_c;
    logic [VEC_W-1:0] s_vec_c;
    logic [VEC_W-1:0] p_vec;

    logic [CNT_W-1:0] cnt_q;
    logic             accepted_q;

    logic [1:0]       sel_c;
    logic             stable_c;
    logic             accept_c;
    logic             glyph_ok_c;
    logic [3:0]       nibble_c;

    logic [3:0]       lo_q;
    logic [3:0]       hi_q;
    logic             got_lo_q;
    logic             got_hi_q;

    logic [7:0]       data_q;
    logic             data_valid_q;
    logic             data_changed_q;
    logic             dp_out_q;
    logic             code_err_q;

    assign raw_vec_c = {bus.en1_n, bus.en2_n, bus.seg, bus.dp};

    // Input synchronizer chain; zero stages passes the pins straight through.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_vec_c = raw_vec_c;
        end else begin : g_sync
            logic [VEC_W-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge CLK) begin
                if (rst) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= raw_vec_c;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s_vec_c = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Select decode: exactly one enable low picks a digit, anything else is idle.
    always_comb begin
        sel_c = SEL_NONE;
        case (s_vec_c[9:8])
            2'b01:   sel_c = SEL_LO;
            2'b10:   sel_c = SEL_HI;
            default: sel_c = SEL_NONE;
        endcase
    end

    assign stable_c = (s_vec_c == p_vec);

    // One acceptance per settled phase: the counter saturates and accepted_q blocks repeats.
    assign accept_c = stable_c && (sel_c != SEL_NONE) && (cnt_q == CNT_MAX) && !accepted_q;

    // Segment pattern to hex nibble.
    always_comb begin
        glyph_ok_c = 1'b1;
        nibble_c   = 4'h0;
        case (s_vec_c[7:1])
            7'b1111110: nibble_c = 4'h0;
            7'b0110000: nibble_c = 4'h1;
            7'b1101101: nibble_c = 4'h2;
            7'b1111001: nibble_c = 4'h3;
            7'b0110011: nibble_c = 4'h4;
            7'b1011011: nibble_c = 4'h5;
            7'b1011111: nibble_c = 4'h6;
            7'b1110000: nibble_c = 4'h7;
            7'b1111111: nibble_c = 4'h8;
            7'b1111011: nibble_c = 4'h9;
            7'b1110111: nibble_c = 4'hA;
            7'b0011111: nibble_c = 4'hB;
            7'b1001110: nibble_c = 4'hC;
            7'b0111101: nibble_c = 4'hD;
            7'b1001111: nibble_c = 4'hE;
            7'b1000111: nibble_c = 4'hF;
            default:    glyph_ok_c = 1'b0;
        endcase
    end

    // Stability counter and acceptance latch.
    always_ff @(posedge CLK) begin
        if (rst) begin
            p_vec      <= '0;
            cnt_q      <= '0;
            accepted_q <= 1'b0;
        end else begin
            p_vec <= s_vec_c;
            if (!stable_c) begin
                cnt_q      <= '0;
                accepted_q <= 1'b0;
            end else if (sel_c == SEL_NONE) begin
                cnt_q <= '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept_c) begin
                accepted_q <= 1'b1;
            end
        end
    end

    // Frame assembly. Completion works from the registered got flags, so an
    // acceptance in the same cycle lands its flag after the clear.
    always_ff @(posedge CLK) begin
        if (rst) begin
            lo_q           <= 4'h0;
            hi_q           <= 4'h0;
            got_lo_q       <= 1'b0;
            got_hi_q       <= 1'b0;
            data_q         <= 8'h00;
            data_valid_q   <= 1'b0;
            data_changed_q <= 1'b0;
            dp_out_q       <= 1'b0;
            code_err_q     <= 1'b0;
        end else begin
            data_valid_q   <= 1'b0;
            data_changed_q <= 1'b0;
            code_err_q     <= 1'b0;

            if (got_lo_q && got_hi_q) begin
                data_q         <= {hi_q, lo_q};
                data_valid_q   <= 1'b1;
                data_changed_q <= ({hi_q, lo_q} != data_q);
                got_lo_q       <= 1'b0;
                got_hi_q       <= 1'b0;
            end

            if (accept_c) begin
                if (glyph_ok_c) begin
                    if (sel_c == SEL_LO) begin
                        lo_q     <= nibble_c;
                        got_lo_q <= 1'b1;
                    end else begin
                        hi_q     <= nibble_c;
                        got_hi_q <= 1'b1;
                    end
                    dp_out_q <= s_vec_c[0];
                end else begin
                    // Bad glyph poisons the whole frame.
                    code_err_q <= 1'b1;
                    got_lo_q   <= 1'b0;
                    got_hi_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.data         = data_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.data_changed = data_changed_q;
    assign bus.dp_out       = dp_out_q;
    assign bus.code_err     = code_err_q;

endmodule

// File: tb/tb_sevenseg_mux_decoder.sv
// Self-checking bench for sevenseg_mux_decoder: directed display streams plus
// randomized phases, compared every cycle against a run-length behavioural model.
module tb_sevenseg_mux_decoder;

    localparam int unsigned P_SYNC   = 2;
    localparam int unsigned P_SETTLE = 16;

    localparam logic [1:0] EN_LO  = 2'b01;
    localparam logic [1:0] EN_HI  = 2'b10;
    localparam logic [1:0] EN_N00 = 2'b00;
    localparam logic [1:0] EN_N11 = 2'b11;

    localparam logic [6:0] G_0 = 7'b1111110;
    localparam logic [6:0] G_3 = 7'b1111001;
    localparam logic [6:0] G_5 = 7'b1011011;
    localparam logic [6:0] G_7 = 7'b1110000;
    localparam logic [6:0] G_A = 7'b1110111;
    localparam logic [6:0] G_F = 7'b1000111;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    always #5 CLK = ~CLK;

    sevenseg_mux_decoder_if bus();

    sevenseg_mux_decoder #(
        .SYNC_STAGES  (P_SYNC),
        .SETTLE_CYCLES(P_SETTLE),
        .CNT_W        (8)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int n_checks = 0;
    int n_pass   = 0;

    // Model: delay line for the sampling path, plus how long the sampled vector has held.
    logic [9:0]  m_pipe [P_SYNC];
    logic [9:0]  m_s;
    int unsigned m_run;
    logic [3:0]  m_lo, m_hi;
    logic        m_got_lo, m_got_hi;
    logic [7:0]  e_data;
    logic        e_valid, e_changed, e_dp, e_err;

    int scn_tick;
    int obs_valid, obs_changed, obs_err, obs_first;
    int mdl_valid, mdl_changed, mdl_err, mdl_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (scenario tick %0d)", name, act, exp, scn_tick);
        end
    endtask

    function automatic logic glyph_lookup(input logic [6:0] sg, output logic [3:0] nib);
        glyph_lookup = 1'b0;
        nib          = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == sg) begin
                glyph_lookup = 1'b1;
                nib          = 4'(i);
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(P_SYNC); i++) m_pipe[i] = '0;
        m_s       = '0;
        m_run     = 2;
        m_lo      = 4'h0;
        m_hi      = 4'h0;
        m_got_lo  = 1'b0;
        m_got_hi  = 1'b0;
        e_data    = 8'h00;
        e_valid   = 1'b0;
        e_changed = 1'b0;
        e_dp      = 1'b0;
        e_err     = 1'b0;
    endtask

    // A digit is taken once the sampled vector has been identical for SETTLE+1 cycles.
    task automatic model_edge();
        logic       acc;
        logic       ok;
        logic [3:0] nib;
        logic [9:0] nxt;
        if (rst) begin
            model_reset();
        end else begin
            acc = (m_run == P_SETTLE + 1) && (m_s[9:8] == EN_LO || m_s[9:8] == EN_HI);
            e_valid   = 1'b0;
            e_changed = 1'b0;
            e_err     = 1'b0;
            if (m_got_lo && m_got_hi) begin
                e_changed = ({m_hi, m_lo} != e_data);
                e_data    = {m_hi, m_lo};
                e_valid   = 1'b1;
                m_got_lo  = 1'b0;
                m_got_hi  = 1'b0;
            end
            if (acc) begin
                ok = glyph_lookup(m_s[7:1], nib);
                if (ok) begin
                    if (m_s[9:8] == EN_LO) begin
                        m_lo = nib; m_got_lo = 1'b1;
                    end else begin
                        m_hi = nib; m_got_hi = 1'b1;
                    end
                    e_dp = m_s[0];
                end else begin
                    e_err    = 1'b1;
                    m_got_lo = 1'b0;
                    m_got_hi = 1'b0;
                end
            end
            for (int i = int'(P_SYNC) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = {bus.en1_n, bus.en2_n, bus.seg, bus.dp};
            nxt = m_pipe[P_SYNC-1];
            if (nxt == m_s) begin
                if (m_run < P_SETTLE + 2) m_run = m_run + 1;
            end else begin
                m_run = 1;
            end
            m_s = nxt;
        end
    endtask

    // One clock: advance the model at the edge, then compare every output.
    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        scn_tick++;
        check("data",         32'(bus.data),         32'(e_data));
        check("data_valid",   32'(bus.data_valid),   32'(e_valid));
        check("data_changed", 32'(bus.data_changed), 32'(e_changed));
        check("dp_out",       32'(bus.dp_out),       32'(e_dp));
        check("code_err",     32'(bus.code_err),     32'(e_err));
        if (bus.data_valid)   begin obs_valid++; if (obs_first < 0) obs_first = scn_tick; end
        if (bus.data_changed) obs_changed++;
        if (bus.code_err)     obs_err++;
        if (e_valid)   begin mdl_valid++; if (mdl_first < 0) mdl_first = scn_tick; end
        if (e_changed) mdl_changed++;
        if (e_err)     mdl_err++;
    endtask

    task automatic set_pins(input logic [1:0] en, input logic [6:0] sg, input logic d);
        bus.en1_n = en[1];
        bus.en2_n = en[0];
        bus.seg   = sg;
        bus.dp    = d;
    endtask

    task automatic phase(input logic [1:0] en, input logic [6:0] sg, input logic d, input int unsigned n);
        set_pins(en, sg, d);
        repeat (n) tick();
    endtask

    task automatic start_scn();
        scn_tick    = 0;
        obs_valid   = 0; obs_changed = 0; obs_err = 0; obs_first = -1;
        mdl_valid   = 0; mdl_changed = 0; mdl_err = 0; mdl_first = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_scn();
    endtask

    // Literal expectation applied to both the DUT observation and the model.
    task automatic pin(input string name, input int dut_v, input int mdl_v, input int exp);
        check({name, "_dut"},   32'(dut_v), 32'(exp));
        check({name, "_model"}, 32'(mdl_v), 32'(exp));
    endtask

    initial begin
        logic [1:0]  en;
        logic [6:0]  sg;
        logic [3:0]  gi;
        logic        d;
        int unsigned r;

        model_reset();
        set_pins(EN_N11, 7'b0, 1'b0);
        start_scn();
        rst = 1'b1;
        tick();
        tick();
        check("reset_data_lit", 32'(bus.data), 32'h0);
        check("reset_valid_lit", 32'(bus.data_valid), 32'h0);

        // Alternating LO 'A' / HI '3': one frame per pair, change only on the first.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            phase(EN_LO, G_A, 1'b0, 64);
            phase(EN_HI, G_3, 1'b0, 64);
        end
        phase(EN_N11, G_3, 1'b0, 8);
        pin("s1_valid", obs_valid, mdl_valid, 4);
        pin("s1_changed", obs_changed, mdl_changed, 1);
        // HI accepted at tick 64+2+16+1, frame published one tick later.
        pin("s1_first_valid_tick", obs_first, mdl_first, 84);
        check("s1_data_lit", 32'(bus.data), 32'h3A);

        // Phases of SETTLE cycles are one short of the minimum stable run.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            phase(EN_LO, G_A, 1'b0, P_SETTLE);
            phase(EN_HI, G_3, 1'b0, P_SETTLE);
        end
        phase(EN_N11, G_3, 1'b0, 8);
        pin("s2_valid", obs_valid, mdl_valid, 0);
        check("s2_data_lit", 32'(bus.data), 32'h00);

        // Short glitch inside a LO phase restarts settling without a duplicate.
        do_reset();
        phase(EN_LO, G_A, 1'b0, 10);
        phase(EN_LO, 7'b0000001, 1'b0, 3);
        phase(EN_LO, G_A, 1'b0, 51);
        phase(EN_HI, G_3, 1'b0, 64);
        phase(EN_N11, G_3, 1'b0, 8);
        pin("s3_valid", obs_valid, mdl_valid, 1);
        pin("s3_err", obs_err, mdl_err, 0);
        check("s3_data_lit", 32'(bus.data), 32'h3A);

        // Invalid HI glyph discards the frame; next good frame is 0x75.
        do_reset();
        phase(EN_HI, 7'b0100000, 1'b0, 64);
        phase(EN_LO, G_5, 1'b0, 64);
        phase(EN_HI, G_7, 1'b0, 64);
        phase(EN_N11, G_7, 1'b0, 8);
        pin("s4_err", obs_err, mdl_err, 1);
        pin("s4_valid", obs_valid, mdl_valid, 1);
        pin("s4_changed", obs_changed, mdl_changed, 1);
        check("s4_data_lit", 32'(bus.data), 32'h75);

        // Long idle selects produce nothing; resuming gives 0xF0.
        do_reset();
        phase(EN_LO, G_A, 1'b0, 64);
        phase(EN_N11, G_A, 1'b0, 200);
        phase(EN_N00, G_3, 1'b1, 200);
        pin("s5_idle_valid", obs_valid, mdl_valid, 0);
        pin("s5_idle_err", obs_err, mdl_err, 0);
        phase(EN_LO, G_0, 1'b0, 64);
        phase(EN_HI, G_F, 1'b0, 64);
        phase(EN_N11, G_F, 1'b0, 8);
        pin("s5_valid", obs_valid, mdl_valid, 1);
        check("s5_data_lit", 32'(bus.data), 32'hF0);

        // Reset after an accepted LO digit, then HI only: no frame.
        do_reset();
        phase(EN_LO, G_5, 1'b1, 64);
        phase(EN_HI, G_7, 1'b1, 64);
        phase(EN_LO, G_A, 1'b1, 40);
        check("s6_pre_data_lit", 32'(bus.data), 32'h75);
        check("s6_pre_dp_lit", 32'(bus.dp_out), 32'h1);
        set_pins(EN_HI, G_3, 1'b0);
        do_reset();
        check("s6_rst_data_lit", 32'(bus.data), 32'h0);
        check("s6_rst_valid_lit", 32'(bus.data_valid), 32'h0);
        check("s6_rst_changed_lit", 32'(bus.data_changed), 32'h0);
        check("s6_rst_dp_lit", 32'(bus.dp_out), 32'h0);
        check("s6_rst_err_lit", 32'(bus.code_err), 32'h0);
        phase(EN_HI, G_3, 1'b0, 64);
        phase(EN_N11, G_3, 1'b0, 8);
        pin("s6_valid", obs_valid, mdl_valid, 0);

        // Random phases of mixed length, select, glyph validity and glitches.
        do_reset();
        for (int k = 0; k < 150; k++) begin
            r  = $urandom_range(0, 9);
            en = (r < 4) ? EN_LO : (r < 8) ? EN_HI : (r == 8) ? EN_N00 : EN_N11;
            gi = 4'($urandom_range(0, 15));
            sg = ($urandom_range(0, 9) < 8) ? glyph[gi] : 7'($urandom);
            d  = 1'($urandom);
            phase(en, sg, d, $urandom_range(3, 40));
            if ($urandom_range(0, 4) == 0) begin
                phase(en, 7'($urandom), d, $urandom_range(1, 4));
                phase(en, sg, d, $urandom_range(3, 40));
            end
        end
        phase(EN_N11, 7'b0, 1'b0, 8);
        check("rnd_valid_count", 32'(obs_valid), 32'(mdl_valid));
        check("rnd_err_count", 32'(obs_err), 32'(mdl_err));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
